// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Contents:
//   dmem_state_t  responder FSM state encoding
//   DMEM_WORD_W   storage word width in bits
//   DMEM_BE_W     byte-enable width
//   dmem_idx_w()  word-index width for a given storage depth
package dmem_pkg;

   typedef enum logic [1:0] {
      DMEM_IDLE,
      DMEM_WAIT,
      DMEM_RESP
   } dmem_state_t;

   localparam int DMEM_WORD_W = 32;
   localparam int DMEM_BE_W   = 4;

   // A depth of 1 would give a zero-width index, so it is clamped to 1 bit.
   function automatic int dmem_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core (master) and the data-memory
// responder (slave).
// Signals:
//   req_valid/req_ready  request handshake
//   req_write            1 = store, 0 = load
//   req_addr             byte address
//   req_wdata/req_be     store data and byte enables
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata/rsp_err    load data and error flag
interface dmem_responder_if;
   import dmem_pkg::*;

   logic                   req_valid;
   logic                   req_ready;
   logic                   req_write;
   logic [31:0]            req_addr;
   logic [DMEM_WORD_W-1:0] req_wdata;
   logic [DMEM_BE_W-1:0]   req_be;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [DMEM_WORD_W-1:0] rsp_rdata;
   logic                   rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_word_array.sv
// Word storage for the data-memory responder: DEPTH_WORDS x 32 bits,
// synchronous byte-enabled write, combinational read. Contents are not reset.
// Ports:
//   i_clk    clock
//   i_we     write strobe for this cycle
//   i_idx    word index (shared by read and write)
//   i_be     byte enables, bit i writes bits 8i+7:8i
//   i_wdata  write data
//   o_rdata  word at i_idx
module dmem_word_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = 8
) (
   input  logic                   i_clk,
   input  logic                   i_we,
   input  logic [IDX_W-1:0]       i_idx,
   input  logic [DMEM_BE_W-1:0]   i_be,
   input  logic [DMEM_WORD_W-1:0] i_wdata,
   output logic [DMEM_WORD_W-1:0] o_rdata
);

   logic [DMEM_WORD_W-1:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < DMEM_BE_W; b++) begin
            if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core's data-memory port. Accepts one load/store at a
// time, waits WAIT_CYCLES, performs the access and holds the response until
// the core takes it.
// Ports:
//   clk    clock, all state changes on posedge
//   reset  asynchronous active-low reset
//   bus    dmem_responder_if slave modport (request/response handshakes)
// Parameters:
//   DEPTH_WORDS  words of storage, word index = req_addr[31:2]
//   WAIT_CYCLES  wait states between accept and response (0 allowed)
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, req_addr[1:0] != 0 is rejected with
//                        rsp_err; otherwise the low address bits are ignored.
//
// state     | meaning
// DMEM_IDLE | req_ready high, waiting for req_valid
// DMEM_WAIT | request captured, counter runs WAIT_CYCLES..0; access on leaving
// DMEM_RESP | rsp_valid high, response held until rsp_ready
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
);

   localparam int IDX_W = dmem_idx_w(DEPTH_WORDS);
   localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   dmem_state_t            r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_write;
   logic [29:0]            r_word;
   logic [DMEM_WORD_W-1:0] r_wdata;
   logic [DMEM_BE_W-1:0]   r_be;
   logic                   r_req_ready;
   logic                   r_rsp_valid;
   logic [DMEM_WORD_W-1:0] r_rsp_rdata;
   logic                   r_rsp_err;
`ifdef DMEM_ALIGN_CHECK_EN
   logic                   r_misalign;
`endif

   logic                   w_range_err;
   logic                   w_align_err;
   logic                   w_err;
   logic                   w_last_wait;
   logic                   w_we;
   logic [IDX_W-1:0]       w_idx;
   logic [DMEM_WORD_W-1:0] w_rdata;

   // Full 30-bit compare so high addresses never alias into the array.
   assign w_range_err = {2'b00, r_word} >= 32'(DEPTH_WORDS);
`ifdef DMEM_ALIGN_CHECK_EN
   assign w_align_err = r_misalign;
`else
   assign w_align_err = 1'b0;
`endif
   assign w_err       = w_range_err | w_align_err;
   assign w_idx       = r_word[IDX_W-1:0];
   // The single memory access happens on the edge that leaves WAIT.
   assign w_last_wait = (r_state == DMEM_WAIT) && (r_cnt == '0);
   assign w_we        = w_last_wait && r_write && !w_err;

   dmem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .i_clk   (clk),
      .i_we    (w_we),
      .i_idx   (w_idx),
      .i_be    (r_be),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= DMEM_IDLE;
         r_cnt       <= '0;
         r_write     <= 1'b0;
         r_word      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
         r_misalign  <= 1'b0;
`endif
      end else begin
         case (r_state)
            DMEM_IDLE: begin
               r_req_ready <= 1'b1;
               if (bus.req_valid && r_req_ready) begin
                  r_write     <= bus.req_write;
                  r_word      <= bus.req_addr[31:2];
                  r_wdata     <= bus.req_wdata;
                  r_be        <= bus.req_be;
`ifdef DMEM_ALIGN_CHECK_EN
                  r_misalign  <= (bus.req_addr[1:0] != 2'b00);
`endif
                  r_req_ready <= 1'b0;
                  r_cnt       <= CNT_W'(WAIT_CYCLES);
                  r_state     <= DMEM_WAIT;
               end
            end
            DMEM_WAIT: begin
               if (w_last_wait) begin
                  r_state     <= DMEM_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_err;
                  r_rsp_rdata <= (r_write || w_err) ? '0 : w_rdata;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            DMEM_RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= DMEM_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: r_state <= DMEM_IDLE;
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] mem_m [256];

   dmem_responder_if bus ();

   dmem_responder #(
      .DEPTH_WORDS (256),
      .WAIT_CYCLES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Reference behaviour: word-addressed array of 256 words, bytes merged by be.
   task automatic model_apply(input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              output logic [31:0] exp_rd, output logic exp_err);
      int unsigned idx;
      idx     = addr >> 2;
      exp_err = (idx >= 256);
`ifdef DMEM_ALIGN_CHECK_EN
      if (addr % 4 != 0) exp_err = 1'b1;
`endif
      exp_rd = '0;
      if (!exp_err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            exp_rd = mem_m[idx];
         end
      end
   endtask

   task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rd, output logic er,
                      output int lat);
      int n;
      rd  = '0;
      er  = 1'b0;
      lat = 0;
      n   = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         checks++; errors++;
         $display("FAIL txn_ready_timeout: req_ready=%b required 1", bus.req_ready);
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_be    = be;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_be    = 4'($urandom);
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!bus.rsp_valid && lat < 20);
      if (!bus.rsp_valid) begin
         checks++; errors++;
         $display("FAIL txn_rsp_timeout: rsp_valid=%b required 1", bus.rsp_valid);
         return;
      end
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      @(posedge clk);
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.req_ready, bus.rsp_valid, bus.rsp_err} !== 3'b000 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h required all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
         end
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready: got %b required 0", bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_release: got %b required 1", bus.req_ready);
      end
   endtask

   task automatic test_fill();
      logic [31:0] rd, erd, wd;
      logic        er, eer;
      int          lat;
      for (int i = 0; i < 256; i++) begin
         wd = $urandom;
         model_apply(1'b1, 32'(i * 4), wd, 4'hF, erd, eer);
         txn(1'b1, 32'(i * 4), wd, 4'hF, rd, er, lat);
         checks++;
         if (er !== eer || rd !== erd) begin
            errors++;
            $display("FAIL fill_store: word %0d err=%b rdata=%h required err=%b rdata=%h",
                     i, er, rd, eer, erd);
         end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      model_apply(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
      checks++;
      if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin
         errors++;
         $display("FAIL store_full: lat=%0d err=%b rdata=%h required lat=3 err=0 rdata=0", lat, er, rd);
      end
      model_apply(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
      txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (lat != 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL load_full: lat=%0d err=%b rdata=%h required lat=3 err=0 rdata=deadbeef", lat, er, rd);
      end
   endtask

   task automatic test_byte_enable();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      model_apply(1'b1, 32'h10, 32'h000000AA, 4'b0001, erd, eer);
      txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
      txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (er !== 1'b0 || rd !== 32'hDEADBEAA) begin
         errors++;
         $display("FAIL byte_lane0: err=%b rdata=%h required err=0 rdata=deadbeaa", er, rd);
      end
      txn(1'b1, 32'h10, 32'h12345678, 4'b0000, rd, er, lat);
      checks++;
      if (er !== 1'b0 || rd !== 32'h0 || lat != 3) begin
         errors++;
         $display("FAIL be_zero_store: err=%b rdata=%h lat=%0d required err=0 rdata=0 lat=3", er, rd, lat);
      end
      txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
      checks++;
      if (rd !== 32'hDEADBEAA) begin
         errors++;
         $display("FAIL be_zero_noop: rdata=%h required deadbeaa", rd);
      end
      model_apply(1'b1, 32'h3FC, 32'hA1B2C3D4, 4'b1010, erd, eer);
      txn(1'b1, 32'h3FC, 32'hA1B2C3D4, 4'b1010, rd, er, lat);
      model_apply(1'b0, 32'h3FC, 32'h0, 4'h0, erd, eer);
      txn(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (er !== eer || rd !== erd) begin
         errors++;
         $display("FAIL last_word_bytes: err=%b rdata=%h required err=%b rdata=%h", er, rd, eer, erd);
      end
   endtask

   task automatic test_range();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      txn(1'b0, 32'h400, 32'h0, 4'hF, rd, er, lat);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 3) begin
         errors++;
         $display("FAIL range_load: err=%b rdata=%h lat=%0d required err=1 rdata=0 lat=3", er, rd, lat);
      end
      txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         errors++;
         $display("FAIL range_store: err=%b rdata=%h required err=1 rdata=0", er, rd);
      end
      txn(1'b1, 32'hFFFF_FC00, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      checks++;
      if (er !== 1'b1) begin
         errors++;
         $display("FAIL range_high_store: err=%b required 1", er);
      end
      for (int i = 0; i < 256; i++) begin
         model_apply(1'b0, 32'(i * 4), 32'h0, 4'h0, erd, eer);
         txn(1'b0, 32'(i * 4), 32'h0, 4'h0, rd, er, lat);
         checks++;
         if (er !== 1'b0 || rd !== erd) begin
            errors++;
            $display("FAIL range_no_alias: word %0d err=%b rdata=%h required err=0 rdata=%h", i, er, rd, erd);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, erd, held;
      logic        er, eer;
      int          lat, n;
      model_apply(1'b1, 32'h14, 32'h12345678, 4'hF, erd, eer);
      txn(1'b1, 32'h14, 32'h12345678, 4'hF, rd, er, lat);
      model_apply(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
      @(negedge clk);
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h10;
      bus.req_be    = 4'hF;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rsp_valid && n < 20);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== erd) begin
         errors++;
         $display("FAIL bp_first: valid=%b rdata=%h required valid=1 rdata=%h", bus.rsp_valid, bus.rsp_rdata, erd);
      end
      held = bus.rsp_rdata;
      // A competing store is presented while the response is stalled.
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h14;
      bus.req_wdata = 32'hBAD0BAD0;
      bus.req_be    = 4'hF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d valid=%b rdata=%h err=%b ready=%b required 1 %h 0 0",
                     i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, held);
         end
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL bp_release: valid=%b ready=%b rdata=%h required 0 1 0",
                  bus.rsp_valid, bus.req_ready, bus.rsp_rdata);
      end
      txn(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h12345678) begin
         errors++;
         $display("FAIL bp_ignored_req: rdata=%h required 12345678", rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd;
      logic        er, eer, seen;
      int          lat, n;
      model_apply(1'b1, 32'h20, 32'h11112222, 4'hF, erd, eer);
      txn(1'b1, 32'h20, 32'h11112222, 4'hF, rd, er, lat);
      @(negedge clk);
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h20;
      bus.req_wdata = 32'h99999999;
      bus.req_be    = 4'hF;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_async: ready=%b valid=%b required 0 0", bus.req_ready, bus.rsp_valid);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen  = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.rsp_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_rsp: rsp_valid seen=%b required 0", seen);
      end
      model_apply(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
      txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h11112222 || er !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_store_dropped: rdata=%h err=%b required 11112222 0", rd, er);
      end
      model_apply(1'b0, 32'h12, 32'h0, 4'h0, erd, eer);
      txn(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (rd !== erd || er !== eer || lat != 3) begin
         errors++;
         $display("FAIL unaligned_load: rdata=%h err=%b lat=%0d required %h %b 3", rd, er, lat, erd, eer);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, addr, wd;
      logic [3:0]  be;
      logic        er, eer, wr;
      int          lat;
      for (int i = 0; i < 80; i++) begin
         wr   = 1'($urandom_range(0, 1));
         addr = 32'($urandom_range(0, 263)) * 4 + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h8000_0000;
         wd = $urandom;
         be = 4'($urandom);
         model_apply(wr, addr, wd, be, erd, eer);
         txn(wr, addr, wd, be, rd, er, lat);
         checks++;
         if (rd !== erd || er !== eer || lat != 3) begin
            errors++;
            $display("FAIL random_txn: #%0d wr=%b addr=%h rdata=%h err=%b lat=%0d required %h %b 3",
                     i, wr, addr, rd, er, lat, erd, eer);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_store_load();
      test_byte_enable();
      test_range();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
